fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end: owns the fetch PC, drives the instruction bus request, and buffers returned instructions in a DEPTH-entry FIFO toward decode.
- Replaces the ad-hoc fetch-stall and jump-versus-fetch-delay coupling with a decoupled queue.
- Redirects (jump, trap, mret) flush the queue and discard any in-flight bus response.
- Sits between the ibus port and the fetch/decode pipeline register.

---
 rtl/fetch_queue.sv | 184 ++++++++++++++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues ibus requests and
// buffers returned instructions in a DEPTH-entry circular FIFO toward decode.
// Redirects (jump/trap/mret) flush the queue and discard any in-flight response.
//
// Handshakes:
//   ibus   : ireq_valid/ireq_addr are held stable until iresp_data_ok, which
//            completes the request in the cycle it is seen high.
//   decode : an entry moves when out_valid & out_ready are both high at a
//            rising edge; out_valid never depends on out_ready.
module fetch_queue #(
  parameter int unsigned      XLEN     = 64,
  parameter int unsigned      ILEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ireq_valid,
  output logic [XLEN-1:0]          ireq_addr,
  input  logic                     iresp_data_ok,
  input  logic [ILEN-1:0]          iresp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [ILEN-1:0]          out_instr,
  output logic                     out_misalign,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  // FSM state is visible hierarchically as 'state' for checkers.
  state_t state;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pending_pc;
  logic [XLEN-1:0] pc_inc;
  logic            pc_misaligned;
  logic            has_room;

  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [ILEN-1:0] fifo_instr [DEPTH];
  logic            fifo_mis   [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  logic            push;
  logic            pop;
  logic [ILEN-1:0] push_instr;
  logic            push_mis;
  logic [CW-1:0]   count_next;

  assign pc_inc        = pc + XLEN'(4);
  assign pc_misaligned = (pc[1:0] != 2'b00);
  assign has_room      = (count < FULL);

  // Push sources: a returned instruction in REQ, or a misaligned-fetch marker
  // from IDLE. A redirect in the same cycle always wins and drops the push.
  always_comb begin
    push       = 1'b0;
    push_instr = '0;
    push_mis   = 1'b0;
    if (!redirect_valid) begin
      if (state == S_REQ && iresp_data_ok) begin
        push       = 1'b1;
        push_instr = iresp_data;
      end else if (state == S_IDLE && pc_misaligned && has_room) begin
        push     = 1'b1;
        push_mis = 1'b1;
      end
    end
  end

  assign pop        = out_valid && out_ready && !redirect_valid;
  assign count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  // Fetch FSM: PC, pending redirect target and the registered request valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      pending_pc <= '0;
      ireq_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (has_room) begin
            if (pc_misaligned) begin
              state <= S_HALT;
            end else begin
              state      <= S_REQ;
              ireq_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            if (iresp_data_ok) begin
              pc         <= redirect_pc;
              state      <= S_IDLE;
              ireq_valid <= 1'b0;
            end else begin
              // Request is still on the bus; its response must be swallowed.
              pending_pc <= redirect_pc;
              state      <= S_DISCARD;
            end
          end else if (iresp_data_ok) begin
            pc <= pc_inc;
            if (!(count_next < FULL) || (pc_inc[1:0] != 2'b00)) begin
              state      <= S_IDLE;
              ireq_valid <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (iresp_data_ok) begin
            pc         <= redirect_valid ? redirect_pc : pending_pc;
            state      <= S_IDLE;
            ireq_valid <= 1'b0;
          end else if (redirect_valid) begin
            pending_pc <= redirect_pc;
          end
        end
        S_HALT: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          ireq_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ireq_addr = pc;

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count_next;
    end
  end

  // FIFO storage; entries are only ever read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail]    <= pc;
      fifo_instr[tail] <= push_instr;
      fifo_mis[tail]   <= push_mis;
    end
  end

  assign out_valid    = (count != '0);
  assign out_pc       = out_valid ? fifo_pc[head]    : '0;
  assign out_instr    = out_valid ? fifo_instr[head] : '0;
  assign out_misalign = out_valid ? fifo_mis[head]   : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus hand-written
// sequences for reset values and asynchronous reset in the middle of a request.
module tb_fetch_queue;

  localparam logic [63:0] B = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;
  logic [2:0]  count;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        rst_n;
    logic        ok;
    logic [31:0] data;
    logic        redir;
    logic [63:0] rpc;
    logic        ready;
    logic        e_iv;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  fetch_queue #(
    .XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h8000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misalign   (out_misalign),
    .count          (count)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add(input logic r, input logic ok, input logic [31:0] d,
                              input logic rv, input logic [63:0] rp, input logic rdy,
                              input logic eiv, input logic [63:0] ea, input logic eov,
                              input logic [63:0] ep, input logic [31:0] ei,
                              input logic em, input logic [2:0] ec);
    vec_t v;
    v.rst_n = r;   v.ok = ok;     v.data = d;     v.redir = rv;   v.rpc = rp;
    v.ready = rdy; v.e_iv = eiv;  v.e_addr = ea;  v.e_ov = eov;   v.e_pc = ep;
    v.e_instr = ei; v.e_mis = em; v.e_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic ok, input logic [31:0] d, input logic rv,
                       input logic [63:0] rp, input logic rdy);
    iresp_data_ok  = ok;
    iresp_data     = d;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    logic bad;
    @(negedge clk);
    reset = v.rst_n;
    drive(v.ok, v.data, v.redir, v.rpc, v.ready);
    #1;
    bad = (ireq_valid !== v.e_iv) || (count !== v.e_cnt) || (out_valid !== v.e_ov);
    if (v.e_iv && ireq_addr !== v.e_addr) bad = 1'b1;
    if (v.e_ov && (out_pc !== v.e_pc || out_instr !== v.e_instr || out_misalign !== v.e_mis))
      bad = 1'b1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL vec%0d (got/exp): iv=%0b/%0b addr=%h/%h ov=%0b/%0b pc=%h/%h instr=%h/%h mis=%0b/%0b cnt=%0d/%0d",
               idx, ireq_valid, v.e_iv, ireq_addr, v.e_addr, out_valid, v.e_ov,
               out_pc, v.e_pc, out_instr, v.e_instr, out_misalign, v.e_mis, count, v.e_cnt);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);

    // Columns: rst_n ok data redir rpc ready | iv addr ov pc instr mis cnt
    // Reset and streaming with data_ok every cycle
    add(0,0,0,0,0,1, 0,0,0,0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0,0,0);
    add(1,1,32'h1111_0000,0,0,1, 0,0,0,0,0,0,0);
    add(1,1,32'h1111_0000,0,0,1, 1,B,0,0,0,0,0);
    add(1,1,32'h1111_0004,0,0,1, 1,B+64'h4,1,B,32'h1111_0000,0,1);
    add(1,1,32'h1111_0008,0,0,1, 1,B+64'h8,1,B+64'h4,32'h1111_0004,0,1);
    add(1,0,0,0,0,1, 1,B+64'hC,1,B+64'h8,32'h1111_0008,0,1);
    add(1,0,0,0,0,1, 1,B+64'hC,0,0,0,0,0);
    // Backpressure to a full queue, then a single pop reopens fetch
    add(0,0,0,0,0,0, 0,0,0,0,0,0,0);
    add(1,1,32'h2222_0000,0,0,0, 0,0,0,0,0,0,0);
    add(1,1,32'h2222_0000,0,0,0, 1,B,0,0,0,0,0);
    add(1,1,32'h2222_0004,0,0,0, 1,B+64'h4,1,B,32'h2222_0000,0,1);
    add(1,1,32'h2222_0008,0,0,0, 1,B+64'h8,1,B,32'h2222_0000,0,2);
    add(1,1,32'h2222_000C,0,0,0, 1,B+64'hC,1,B,32'h2222_0000,0,3);
    add(1,1,0,0,0,0, 0,0,1,B,32'h2222_0000,0,4);
    add(1,0,0,0,0,1, 0,0,1,B,32'h2222_0000,0,4);
    add(1,0,0,0,0,0, 0,0,1,B+64'h4,32'h2222_0004,0,3);
    add(1,0,0,0,0,0, 1,B+64'h10,1,B+64'h4,32'h2222_0004,0,3);
    add(1,1,32'h2222_0010,0,0,0, 1,B+64'h10,1,B+64'h4,32'h2222_0004,0,3);
    add(1,0,0,0,0,0, 0,0,1,B+64'h4,32'h2222_0004,0,4);
    // Redirect while a request is pending; its response is discarded
    add(0,0,0,0,0,1, 0,0,0,0,0,0,0);
    add(1,1,32'h3333_0000,0,0,1, 0,0,0,0,0,0,0);
    add(1,1,32'h3333_0000,0,0,1, 1,B,0,0,0,0,0);
    add(1,1,32'h3333_0004,0,0,1, 1,B+64'h4,1,B,32'h3333_0000,0,1);
    add(1,0,0,1,B+64'h100,1, 1,B+64'h8,1,B+64'h4,32'h3333_0004,0,1);
    add(1,0,0,0,0,1, 1,B+64'h8,0,0,0,0,0);
    add(1,1,32'hDEAD_BEEF,0,0,1, 1,B+64'h8,0,0,0,0,0);
    add(1,0,0,0,0,1, 0,0,0,0,0,0,0);
    add(1,0,0,0,0,1, 1,B+64'h100,0,0,0,0,0);
    add(1,1,32'h4444_0100,0,0,1, 1,B+64'h100,0,0,0,0,0);
    add(1,0,0,0,0,1, 1,B+64'h104,1,B+64'h100,32'h4444_0100,0,1);
    add(1,0,0,0,0,1, 1,B+64'h104,0,0,0,0,0);
    // Two redirects before the discarded response: the latest wins
    add(1,0,0,1,B+64'h300,1, 1,B+64'h104,0,0,0,0,0);
    add(1,0,0,1,B+64'h400,1, 1,B+64'h104,0,0,0,0,0);
    add(1,1,32'hDEAD_BEEF,0,0,1, 1,B+64'h104,0,0,0,0,0);
    add(1,0,0,0,0,1, 0,0,0,0,0,0,0);
    add(1,0,0,0,0,1, 1,B+64'h400,0,0,0,0,0);
    // Redirect coinciding with data_ok to a misaligned target, then resume
    add(1,1,32'h5555_0400,1,B+64'h102,1, 1,B+64'h400,0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,1,B+64'h102,0,1,1);
    add(1,0,0,0,0,0, 0,0,1,B+64'h102,0,1,1);
    add(1,0,0,1,B+64'h200,0, 0,0,1,B+64'h102,0,1,1);
    add(1,0,0,0,0,0, 0,0,0,0,0,0,0);
    add(1,1,32'h6666_0200,0,0,0, 1,B+64'h200,0,0,0,0,0);
    add(1,0,0,0,0,0, 1,B+64'h204,1,B+64'h200,32'h6666_0200,0,1);

    // Reset values while reset is held from time zero
    #2;
    check("rst_ireq_valid",   64'(ireq_valid),   64'd0);
    check("rst_out_valid",    64'(out_valid),    64'd0);
    check("rst_count",        64'(count),        64'd0);
    check("rst_out_misalign", 64'(out_misalign), 64'd0);
    check("rst_out_pc",       out_pc,            64'd0);
    check("rst_out_instr",    64'(out_instr),    64'd0);

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Asynchronous reset between clock edges while a request is on the bus
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    check("mid_req_ireq_valid", 64'(ireq_valid), 64'd1);
    check("mid_req_out_valid",  64'(out_valid),  64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("async_rst_out_valid",  64'(out_valid),  64'd0);
    check("async_rst_count",      64'(count),      64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_idle", 64'(ireq_valid), 64'd0);
    @(negedge clk);
    #1;
    check("post_rst_ireq_valid", 64'(ireq_valid), 64'd1);
    check("post_rst_ireq_addr",  ireq_addr,       B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
